// File: rtl/ffs_iterator.sv
// Sequential find-first-set iterator: accepts an N-bit mask and emits the position
// of every set bit, one per handshake, LSB-first or MSB-first, with ordinal and last flag.
module ffs_iterator #(
  parameter int  N         = 16,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int W         = $clog2(N),
  localparam int CW        = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [N-1:0]  load_data,
  output logic          pos_valid,
  input  logic          pos_ready,
  output logic [W-1:0]  pos_out,
  output logic [CW-1:0] idx_out,
  output logic          pos_last,
  output logic          empty_pulse,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    mask_q,  mask_d;
  logic [CW-1:0]   idx_q,   idx_d;
  logic            empty_q, empty_d;

  logic [W-1:0]    enc_pos;
  logic [N-1:0]    mask_cleared;
  logic            single_bit;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign single_bit = (mask_q != '0) && ((mask_q & (mask_q - N'(1))) == '0);

  // Priority encoder; the last matching iteration wins, so loop direction picks the end.
  always_comb begin
    enc_pos = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < N; i++) begin
        if (mask_q[i]) enc_pos = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (mask_q[i]) enc_pos = W'(i);
      end
    end
  end

  always_comb begin
    if (MSB_FIRST) mask_cleared = mask_q & ~(N'(1) << enc_pos);
    else           mask_cleared = mask_q & (mask_q - N'(1));
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its _d input, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      empty_q <= empty_d;
    end
  end

  // NOTE: every variable gets a default before any branch, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    empty_d = 1'b0;
    if (flush) begin
      state_d = IDLE;
      mask_d  = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid && load_ready) begin
            if (load_data != '0) begin
              state_d = SCAN;
              mask_d  = load_data;
              idx_d   = '0;
            end else begin
              empty_d = 1'b1;
            end
          end
        end
        SCAN: begin
          if (pos_ready) begin
            mask_d = mask_cleared;
            idx_d  = idx_q + CW'(1);
            if (single_bit) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs are forced to zero outside SCAN so IDLE never shows stale positions.
  always_comb begin
    busy        = (state_q == SCAN);
    load_ready  = (state_q == IDLE) && !flush;
    pos_valid   = busy;
    pos_out     = busy ? enc_pos : '0;
    idx_out     = busy ? idx_q   : '0;
    pos_last    = busy && single_bit;
    empty_pulse = empty_q;
  end

endmodule

// File: tb/tb_ffs_iterator.sv
// Scoreboard bench for ffs_iterator: one LSB-first and one MSB-first instance,
// directed masks with hand-computed position lists checked by per-instance monitors.
module tb_ffs_iterator;

  localparam int N  = 16;
  localparam int W  = 4;
  localparam int CW = 5;

  typedef struct {
    logic [W-1:0]  pos;
    logic [CW-1:0] idx;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic          a_flush, a_load_valid, a_load_ready, a_pos_valid, a_pos_ready;
  logic [N-1:0]  a_load_data;
  logic [W-1:0]  a_pos_out;
  logic [CW-1:0] a_idx_out;
  logic          a_pos_last, a_empty_pulse, a_busy;

  logic          b_flush, b_load_valid, b_load_ready, b_pos_valid, b_pos_ready;
  logic [N-1:0]  b_load_data;
  logic [W-1:0]  b_pos_out;
  logic [CW-1:0] b_idx_out;
  logic          b_pos_last, b_empty_pulse, b_busy;

  exp_t q_a[$];
  exp_t q_b[$];

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ffs_iterator #(.N(N), .MSB_FIRST(1'b0)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .load_valid(a_load_valid), .load_ready(a_load_ready), .load_data(a_load_data),
    .pos_valid(a_pos_valid), .pos_ready(a_pos_ready), .pos_out(a_pos_out),
    .idx_out(a_idx_out), .pos_last(a_pos_last), .empty_pulse(a_empty_pulse), .busy(a_busy)
  );

  ffs_iterator #(.N(N), .MSB_FIRST(1'b1)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .load_valid(b_load_valid), .load_ready(b_load_ready), .load_data(b_load_data),
    .pos_valid(b_pos_valid), .pos_ready(b_pos_ready), .pos_out(b_pos_out),
    .idx_out(b_idx_out), .pos_last(b_pos_last), .empty_pulse(b_empty_pulse), .busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input bit sel, input int pos, input int idx, input bit last);
    exp_t e;
    e.pos  = W'(pos);
    e.idx  = CW'(idx);
    e.last = last;
    if (sel) q_b.push_back(e);
    else     q_a.push_back(e);
  endtask

  // Offer one mask; returns one cycle after acceptance with pos_ready set to rdy.
  task automatic load(input bit sel, input logic [N-1:0] d, input logic rdy);
    @(posedge clk); #1;
    if (sel) begin
      check("b_load_ready_before_load", b_load_ready, 1);
      b_load_valid = 1'b1; b_load_data = d;
      @(posedge clk); #1;
      b_load_valid = 1'b0; b_pos_ready = rdy;
    end else begin
      check("a_load_ready_before_load", a_load_ready, 1);
      a_load_valid = 1'b1; a_load_data = d;
      @(posedge clk); #1;
      a_load_valid = 1'b0; a_pos_ready = rdy;
    end
  endtask

  // Wait until the scoreboard is drained, then confirm the block is back in IDLE.
  task automatic drain(input bit sel, input string name, output int cycles);
    int sz;
    cycles = 0;
    sz = -1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #2;
      cycles++;
      sz = sel ? q_b.size() : q_a.size();
      if (sz == 0) break;
    end
    check({name, "_drain_timeout"}, sz, 0);
    check({name, "_load_ready_after"}, sel ? b_load_ready : a_load_ready, 1);
    check({name, "_pos_valid_after"},  sel ? b_pos_valid  : a_pos_valid,  0);
    check({name, "_busy_after"},       sel ? b_busy       : a_busy,       0);
  endtask

  always @(negedge clk) begin
    if (!rst && a_pos_valid) begin
      if (q_a.size() == 0) begin
        check("a_unexpected_valid", 1, 0);
      end else begin
        check("a_pos",  a_pos_out,  q_a[0].pos);
        check("a_idx",  a_idx_out,  q_a[0].idx);
        check("a_last", a_pos_last, q_a[0].last);
        if (a_pos_ready && !a_flush) void'(q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && b_pos_valid) begin
      if (q_b.size() == 0) begin
        check("b_unexpected_valid", 1, 0);
      end else begin
        check("b_pos",  b_pos_out,  q_b[0].pos);
        check("b_idx",  b_idx_out,  q_b[0].idx);
        check("b_last", b_pos_last, q_b[0].last);
        if (b_pos_ready && !b_flush) void'(q_b.pop_front());
      end
    end
  end

  initial begin
    int cyc;
    int valid_cycles;

    rst = 1'b1;
    a_flush = 0; a_load_valid = 0; a_load_data = '0; a_pos_ready = 0;
    b_flush = 0; b_load_valid = 0; b_load_data = '0; b_pos_ready = 0;
    #2;
    check("rst_a_pos_valid",   a_pos_valid,   0);
    check("rst_a_load_ready",  a_load_ready,  1);
    check("rst_a_busy",        a_busy,        0);
    check("rst_a_empty_pulse", a_empty_pulse, 0);
    check("rst_a_pos_out",     a_pos_out,     0);
    check("rst_a_idx_out",     a_idx_out,     0);
    check("rst_a_pos_last",    a_pos_last,    0);
    check("rst_b_load_ready",  b_load_ready,  1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Test 1: LSB-first 0x8421 at full rate.
    push(0, 0, 0, 0); push(0, 5, 1, 0); push(0, 10, 2, 0); push(0, 15, 3, 1);
    load(0, 16'h8421, 1'b1);
    drain(0, "t1", cyc);
    check("t1_cycles", cyc, 4);

    // Test 2: MSB-first 0x8421.
    push(1, 15, 0, 0); push(1, 10, 1, 0); push(1, 5, 2, 0); push(1, 0, 3, 1);
    load(1, 16'h8421, 1'b1);
    drain(1, "t2", cyc);
    check("t2_cycles", cyc, 4);

    // Test 3: empty mask pulses once and emits nothing.
    load(0, 16'h0000, 1'b1);
    check("t3_empty_pulse_on",  a_empty_pulse, 1);
    check("t3_pos_valid",       a_pos_valid,   0);
    check("t3_load_ready",      a_load_ready,  1);
    @(posedge clk); #1;
    check("t3_empty_pulse_off", a_empty_pulse, 0);
    check("t3_busy",            a_busy,        0);

    // Test 4: full mask with pos_ready toggling 1,0,1,0.
    for (int i = 0; i < N; i++) push(0, i, i, i == N - 1);
    load(0, 16'hFFFF, 1'b1);
    valid_cycles = 0;
    for (int c = 0; c < 80; c++) begin
      if (!a_pos_valid) break;
      valid_cycles++;
      @(posedge clk); #1;
      a_pos_ready = ~a_pos_ready;
    end
    check("t4_valid_cycles", valid_cycles, 31);
    check("t4_queue_left",   q_a.size(), 0);
    check("t4_load_ready",   a_load_ready, 1);
    a_pos_ready = 1'b1;

    // Test 5: flush while position 6 of 0x00F0 is offered.
    push(0, 4, 0, 0); push(0, 5, 1, 0); push(0, 6, 2, 0);
    load(0, 16'h00F0, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_flush = 1'b1;
    a_load_valid = 1'b1; a_load_data = 16'h0000;
    #1;
    check("t5_load_ready_during_flush", a_load_ready, 0);
    @(posedge clk); #1;
    a_flush = 1'b0; a_load_valid = 1'b0;
    check("t5_pos_valid_after_flush", a_pos_valid,   0);
    check("t5_busy_after_flush",      a_busy,        0);
    check("t5_no_empty_pulse",        a_empty_pulse, 0);
    check("t5_pos6_not_consumed",     q_a.size(),    1);
    q_a.delete();
    // Flush in IDLE blocks a concurrent load.
    a_flush = 1'b1; a_load_valid = 1'b1; a_load_data = 16'h0003;
    #1;
    check("t5_idle_flush_load_ready", a_load_ready, 0);
    @(posedge clk); #1;
    a_flush = 1'b0; a_load_valid = 1'b0;
    check("t5_idle_flush_busy",  a_busy,        0);
    check("t5_idle_flush_empty", a_empty_pulse, 0);
    push(0, 0, 0, 1);
    load(0, 16'h0001, 1'b1);
    drain(0, "t5", cyc);

    // Test 6: asynchronous reset mid-scan of 0x0F00 after one handshake.
    push(0, 8, 0, 0); push(0, 9, 1, 0);
    load(0, 16'h0F00, 1'b1);
    @(posedge clk); #1;
    a_pos_ready = 1'b0;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    check("t6_pos_valid",   a_pos_valid,   0);
    check("t6_pos_out",     a_pos_out,     0);
    check("t6_idx_out",     a_idx_out,     0);
    check("t6_pos_last",    a_pos_last,    0);
    check("t6_busy",        a_busy,        0);
    check("t6_empty_pulse", a_empty_pulse, 0);
    check("t6_load_ready",  a_load_ready,  1);
    check("t6_queue_left",  q_a.size(),    1);
    q_a.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push(0, 10, 0, 0); push(0, 11, 1, 1);
    load(0, 16'h0C00, 1'b1);
    drain(0, "t6", cyc);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
